// File: rtl/cell_updater.sv
// rtl/cell_updater.sv - Game of Life generation engine, one cell per 11 cycles
//
// Purpose: sweeps the grid row-major. For each cell it issues nine reads
// (self, then eight neighbours clockwise from upper), waits one cycle for the
// last read to return, and writes the next-generation state.
// Compile-time option: GOL_TORUS_EN - neighbours wrap around the grid edges;
// when undefined, off-grid neighbours count as dead and their read slot is idle.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - one-cycle request to compute a generation
//   busy       - sweep in progress
//   done       - one-cycle pulse at sweep completion
//   rd_en      - read strobe, current-generation memory
//   rd_addr    - read address {y,x}, zero when rd_en is low
//   rd_data    - cell state, valid the cycle after rd_en
//   wr_en      - write strobe, next-generation memory
//   wr_addr    - write address {y,x}, zero when wr_en is low
//   wr_data    - new cell state
//   live_count - live cells written in the last completed sweep

module cell_updater #(
   parameter int MAX_i = 63,
   parameter int MAX_j = 47,
   parameter int XW    = 6,
   parameter int YW    = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [YW+XW-1:0]     rd_addr,
   input  logic                 rd_data,
   output logic                 wr_en,
   output logic [YW+XW-1:0]     wr_addr,
   output logic                 wr_data,
   output logic [YW+XW:0]       live_count
);

   localparam int AW = YW + XW;
   localparam logic [XW-1:0] XMAX = XW'(MAX_i);
   localparam logic [YW-1:0] YMAX = YW'(MAX_j);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FIN} state_t;

   state_t        state;
   logic [3:0]    k;
   logic [3:0]    count;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          self_q;
   logic          rd_en_d;   // whether the data now on rd_data was really read
   logic [AW:0]   acc;

   // Returns {strobe, address} for neighbour slot kk of cell (cx, cy).
   // The address is zeroed when the slot is idle so rd_addr stays 0.
   function automatic logic [AW:0] slot_addr(input logic [3:0]    kk,
                                             input logic [XW-1:0] cx,
                                             input logic [YW-1:0] cy);
      logic [1:0]    dx;     // 0: same, 1: +1, 2: -1
      logic [1:0]    dy;
      logic [XW-1:0] nx;
      logic [YW-1:0] ny;
      logic          ok;
      case (kk)
         4'd0:    begin dx = 2'd0; dy = 2'd0; end
         4'd1:    begin dx = 2'd0; dy = 2'd2; end
         4'd2:    begin dx = 2'd1; dy = 2'd2; end
         4'd3:    begin dx = 2'd1; dy = 2'd0; end
         4'd4:    begin dx = 2'd1; dy = 2'd1; end
         4'd5:    begin dx = 2'd0; dy = 2'd1; end
         4'd6:    begin dx = 2'd2; dy = 2'd1; end
         4'd7:    begin dx = 2'd2; dy = 2'd0; end
         default: begin dx = 2'd2; dy = 2'd2; end
      endcase
      nx = cx;
      if (dx == 2'd1)      nx = (cx == XMAX) ? '0 : cx + 1'b1;
      else if (dx == 2'd2) nx = (cx == '0) ? XMAX : cx - 1'b1;
      ny = cy;
      if (dy == 2'd1)      ny = (cy == YMAX) ? '0 : cy + 1'b1;
      else if (dy == 2'd2) ny = (cy == '0) ? YMAX : cy - 1'b1;
`ifdef GOL_TORUS_EN
      ok = 1'b1;
`else
      ok = !((dx == 2'd1 && cx == XMAX) || (dx == 2'd2 && cx == '0) ||
             (dy == 2'd1 && cy == YMAX) || (dy == 2'd2 && cy == '0));
`endif
      return ok ? {1'b1, ny, nx} : '0;
   endfunction

   // Idle slots read as dead regardless of what rd_data shows.
   logic          contrib;
   logic [3:0]    count_fin;
   logic          new_cell;
   logic [AW:0]   acc_next;
   logic          last_cell;
   logic [XW-1:0] x_next;
   logic [YW-1:0] y_next;

   assign contrib   = rd_data & rd_en_d;
   assign count_fin = count + {3'b000, contrib};
   assign new_cell  = (count_fin == 4'd3) | (self_q & (count_fin == 4'd2));
   assign acc_next  = acc + {{AW{1'b0}}, wr_data};
   assign last_cell = (x == XMAX) && (y == YMAX);
   assign x_next    = (x == XMAX) ? '0 : x + 1'b1;
   assign y_next    = (x == XMAX) ? y + 1'b1 : y;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         count      <= '0;
         x          <= '0;
         y          <= '0;
         self_q     <= 1'b0;
         rd_en_d    <= 1'b0;
         acc        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 1'b0;
         live_count <= '0;
      end else begin
         rd_en_d <= rd_en;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= FETCH;
                  k       <= '0;
                  x       <= '0;
                  y       <= '0;
                  count   <= '0;
                  acc     <= '0;
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;   // self of cell {0,0}
               end
            end
            FETCH: begin
               // rd_data now carries the result of slot k-1
               if (k == 4'd1)      self_q <= contrib;
               else if (k != 4'd0) count  <= count_fin;
               if (k == 4'd8) begin
                  state <= DRAIN;
               end else begin
                  k                  <= k + 4'd1;
                  {rd_en, rd_addr}   <= slot_addr(k + 4'd1, x, y);
               end
            end
            DRAIN: begin
               state   <= WRITE;
               wr_en   <= 1'b1;
               wr_addr <= {y, x};
               wr_data <= new_cell;
            end
            WRITE: begin
               if (last_cell) begin
                  // live_count and done appear together in the FIN cycle
                  state      <= FIN;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  live_count <= acc_next;
                  acc        <= acc_next;
               end else begin
                  state   <= FETCH;
                  k       <= '0;
                  count   <= '0;
                  x       <= x_next;
                  y       <= y_next;
                  acc     <= acc_next;
                  rd_en   <= 1'b1;
                  rd_addr <= {y_next, x_next};
               end
            end
            FIN: begin
               state <= IDLE;
               k     <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_updater.sv
// tb/tb_cell_updater.sv - scoreboard bench for cell_updater on a 4x4 grid
//
// Purpose: models the current-generation memory, issues directed sweeps and
// checks every write, each done pulse, live_count and strobe rules.
// Compile-time option: GOL_TORUS_EN selects the wrap-around expectations.
// Ports: none (top-level bench).

module tb_cell_updater;

   localparam int MI  = 3;
   localparam int MJ  = 3;
   localparam int XW  = 2;
   localparam int YW  = 2;
   localparam int AW  = 4;
   localparam int N   = 16;
   localparam int LAT = 177;
`ifdef GOL_TORUS_EN
   localparam int RDS = 144;
`else
   localparam int RDS = 100;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_data;
   logic [AW:0]   live_count;

   always #5 clk = ~clk;

   cell_updater #(.MAX_i(MI), .MAX_j(MJ), .XW(XW), .YW(YW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .live_count(live_count)
   );

   typedef struct { int unsigned addr; int unsigned data; } wr_t;
   typedef struct { int unsigned cyc; int unsigned live; int unsigned rds; } dn_t;

   wr_t           wr_q[$];
   dn_t           dn_q[$];
   logic [N-1:0]  grid = '0;
   int unsigned   cyc = 0;
   int unsigned   rd_cnt = 0;
   int unsigned   proto_err = 0;
   int unsigned   done_seen = 0;
   int            chk_cnt = 0;
   int            pass_cnt = 0;
   logic          pend_en = 1'b0;
   logic [AW-1:0] pend_addr = '0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic flag(input string name);
      chk_cnt++;
      $display("FAIL %s", name);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: data returned the cycle after the read; idle slots show 1
   // so an ungated contribution would be visible.
   initial begin
      rd_data = 1'b1;
      forever begin
         @(negedge clk);
         rd_data   = pend_en ? grid[pend_addr] : 1'b1;
         pend_en   = rd_en;
         pend_addr = rd_addr;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a write or done.
   initial forever begin
      wr_t e;
      dn_t d;
      @(negedge clk);
      if (rd_en && wr_en) proto_err++;
      if (!rd_en && rd_addr != '0) proto_err++;
      if (!wr_en && wr_addr != '0) proto_err++;
      if (rd_en) rd_cnt++;
      if (wr_en) begin
         if (wr_q.size() == 0) flag($sformatf("unexpected_write addr=%0d data=%0d", wr_addr, wr_data));
         else begin
            e = wr_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check($sformatf("wr_data[%0d]", e.addr), wr_data, e.data);
         end
      end
      if (done) begin
         done_seen++;
         if (dn_q.size() == 0) flag($sformatf("unexpected_done at cycle %0d", cyc));
         else begin
            d = dn_q.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("live_count", live_count, d.live);
            check("reads_per_sweep", rd_cnt, d.rds);
         end
         rd_cnt = 0;
      end
   end

   // Loads the grid, queues expectations and pulses start for one cycle.
   task automatic kick(input logic [N-1:0] g, input logic [N-1:0] nxt, input int unsigned live,
                       output int unsigned s_cyc);
      wr_t e;
      dn_t d;
      grid = g;
      for (int i = 0; i < N; i++) begin
         e.addr = i;
         e.data = nxt[i];
         wr_q.push_back(e);
      end
      @(negedge clk);
      start  = 1'b1;
      s_cyc  = cyc;
      d.cyc  = cyc + LAT;
      d.live = live;
      d.rds  = RDS;
      dn_q.push_back(d);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (!done && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!done) flag($sformatf("timeout_%s", name));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s;
      int unsigned seen;
      rst   = 1'b1;
      start = 1'b1;   // reset must win over start
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_live_count", live_count, 0);
      start = 1'b0;
      rst   = 1'b0;
      repeat (2) @(negedge clk);

      // Blinker: horizontal row y=1 becomes vertical column x=1
      kick(16'h0070, 16'h0222, 3, s);
      wait_done("blinker");
      repeat (3) @(negedge clk);
      check("live_count_hold", live_count, 3);

      // Corner cells: torus sees four mutual neighbours, bounded grid sees none
`ifdef GOL_TORUS_EN
      kick(16'h1009, 16'h9009, 4, s);
`else
      kick(16'h1009, 16'h0000, 0, s);
`endif
      wait_done("wrap");
      repeat (2) @(negedge clk);

      // Block still life
      kick(16'h0660, 16'h0660, 4, s);
      wait_done("block");
      repeat (2) @(negedge clk);

      // Empty grid twice, second start on the cycle IDLE is re-entered
      kick(16'h0000, 16'h0000, 0, s);
      wait_done("empty1");
      kick(16'h0000, 16'h0000, 0, s);
      wait_done("empty2");
      repeat (2) @(negedge clk);

      // Starts during a sweep are ignored
      seen = done_seen;
      kick(16'h0660, 16'h0660, 4, s);
      repeat (18) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (79) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");
      repeat (250) @(negedge clk);
      check("done_count_ignored_start", done_seen - seen, 1);

      // Reset at cycle 50 of a blinker sweep
      seen = done_seen;
      kick(16'h0070, 16'h0222, 3, s);
      repeat (48) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_done", done, 0);
      check("abort_live_count", live_count, 0);
      check("abort_writes_left", wr_q.size(), 12);
      wr_q.delete();
      dn_q.delete();
      #1;
      rd_cnt = 0;
      repeat (200) @(negedge clk);
      check("abort_no_done", done_seen - seen, 0);
      check("abort_busy_idle", busy, 0);

      check("protocol_violations", proto_err, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
